// File: rtl/prog_tick_gen.sv
// prog_tick_gen: programmable periodic / one-shot tick generator.
// Optional mid-period output tick_half enabled by define TICK_HALF_EN.
module prog_tick_gen #(
  parameter int CNT_W      = 24,
  parameter int DEF_PERIOD = 500_000,
  parameter int TCNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic              start,
  input  logic              period_ld,
  input  logic [CNT_W-1:0]  period_in,
  output logic              tick,
  output logic              busy,
  output logic              period_err,
`ifdef TICK_HALF_EN
  output logic              tick_half,
`endif
  output logic [TCNT_W-1:0] tick_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    ONESHOT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEF_PERIOD);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);
  localparam logic [TCNT_W-1:0] TC1  = TCNT_W'(1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] period_act;
  logic [CNT_W-1:0] shadow;
  logic             pend;
  logic             wrap;
  logic             tick_d;
  logic             ld_ok;
  logic             ld_bad;
  logic             active;

  assign active = (state_q != IDLE);
  assign wrap   = active && (counter == period_act - ONE);
  assign tick_d = en && wrap;
  assign ld_bad = period_ld && (period_in < TWO);
  assign ld_ok  = period_ld && !ld_bad;
  assign busy   = active;

`ifdef TICK_HALF_EN
  assign tick_half = active &&
    (counter == (period_act >> 1) - ONE);
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; en low aborts from anywhere
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (en && !mode)
          state_d = RUN;
        else if (en && mode && start)
          state_d = ONESHOT;
      end
      RUN: begin
        if (!en) state_d = IDLE;
      end
      ONESHOT: begin
        if (!en || wrap) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Period counter: runs 0..P-1 while active
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      counter <= '0;
    else if (!en || !active || wrap)
      counter <= '0;
    else
      counter <= counter + ONE;
  end

  // Tick pulse and running tick count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick       <= 1'b0;
      tick_count <= '0;
    end else begin
      tick <= tick_d;
      if (tick_d) tick_count <= tick_count + TC1;
    end
  end

  // Period load: direct in IDLE, shadowed until wrap when busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_act <= DEF_P;
      shadow     <= '0;
      pend       <= 1'b0;
      period_err <= 1'b0;
    end else begin
      period_err <= ld_bad;
      if (!active) begin
        if (ld_ok) begin
          period_act <= period_in;
          pend       <= 1'b0;
        end else if (pend) begin
          period_act <= shadow;
          pend       <= 1'b0;
        end
      end else begin
        if (tick_d && pend)
          period_act <= shadow;
        if (ld_ok) begin
          shadow <= period_in;
          pend   <= 1'b1;
        end else if (tick_d) begin
          pend <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_tick_gen.sv
// tb_prog_tick_gen: directed vector table plus
// hand sequences for reload, one-shot, abort, reset, wrap.
module tb_prog_tick_gen;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        mode;
  logic        start;
  logic        period_ld;
  logic [23:0] period_in;
  logic        tick;
  logic        busy;
  logic        period_err;
  logic [7:0]  tick_count;
`ifdef TICK_HALF_EN
  logic        tick_half;
`endif

  int ncmp;
  int nerr;

  prog_tick_gen #(
    .CNT_W(24),
    .DEF_PERIOD(500_000),
    .TCNT_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .mode(mode),
    .start(start),
    .period_ld(period_ld),
    .period_in(period_in),
    .tick(tick),
    .busy(busy),
    .period_err(period_err),
`ifdef TICK_HALF_EN
    .tick_half(tick_half),
`endif
    .tick_count(tick_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        mode;
    logic        start;
    logic        ld;
    logic [23:0] pin;
    logic        etick;
    logic        ebusy;
    logic        eerr;
    logic [7:0]  ecnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(
    input logic en_i, input logic ld_i,
    input logic [23:0] pin_i,
    input logic t_i, input logic b_i,
    input logic e_i, input logic [7:0] c_i);
    vec_t v;
    v.en = en_i; v.mode = 1'b0; v.start = 1'b0;
    v.ld = ld_i; v.pin = pin_i;
    v.etick = t_i; v.ebusy = b_i;
    v.eerr = e_i; v.ecnt = c_i;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm,
    input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d",
        nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(output int n);
    bit got;
    n = 0;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      step();
      n++;
      got = tick;
    end
    if (!got) begin
      ncmp++;
      nerr++;
      $display("FAIL tick_timeout: got 0 expected 1");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;
    int bad;
    ncmp = 0;
    nerr = 0;

    // periodic table: v0 loads P=5, v1 is edge 0
    add(0, 1, 5, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++)
      add(1, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 1, 1, 0, 1);
    add(1, 0, 0, 0, 1, 0, 1);
    add(1, 1, 1, 0, 1, 1, 1);
    add(1, 0, 0, 0, 1, 0, 1);
    add(1, 0, 0, 0, 1, 0, 1);
    add(1, 0, 0, 1, 1, 0, 2);
    for (int i = 0; i < 4; i++)
      add(1, 0, 0, 0, 1, 0, 2);
    add(1, 0, 0, 1, 1, 0, 3);

    rst_n = 1'b0;
    en = 0; mode = 0; start = 0;
    period_ld = 0; period_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tick", tick, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", period_err, 0);
    chk("rst_cnt", tick_count, 0);
    chk("rst_period", dut.period_act, 500_000);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      en = tbl[i].en;
      mode = tbl[i].mode;
      start = tbl[i].start;
      period_ld = tbl[i].ld;
      period_in = tbl[i].pin;
      step();
      chk($sformatf("v%0d_tick", i), tick, tbl[i].etick);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].ebusy);
      chk($sformatf("v%0d_err", i), period_err, tbl[i].eerr);
      chk($sformatf("v%0d_cnt", i), tick_count, tbl[i].ecnt);
    end
    period_ld = 0;

    // reload 8 two cycles before a wrap
    step();
    step();
    period_ld = 1; period_in = 8;
    step();
    period_ld = 0;
    wait_tick(n);
    chk("reload_gap0", n, 2);
    wait_tick(n);
    chk("reload_gap1", n, 8);
    wait_tick(n);
    chk("reload_gap2", n, 8);
    chk("reload_cnt", tick_count, 6);

    // load on the wrap edge waits a full period
    repeat (7) step();
    period_ld = 1; period_in = 5;
    step();
    period_ld = 0;
    chk("samewrap_tick", tick, 1);
    wait_tick(n);
    chk("samewrap_gap0", n, 8);
    wait_tick(n);
    chk("samewrap_gap1", n, 5);
    chk("samewrap_cnt", tick_count, 9);

    // abort at counter 2
    step();
    step();
    chk("abort_ctr", dut.counter, 2);
    en = 0;
    step();
    chk("abort_busy", busy, 0);
    chk("abort_tick", tick, 0);
    chk("abort_clr", dut.counter, 0);
    seen = 0;
    repeat (8) begin
      step();
      seen += int'(tick);
    end
    chk("abort_noticks", seen, 0);
    chk("abort_cnt", tick_count, 9);

    // one-shot P=4
    period_ld = 1; period_in = 4;
    step();
    period_ld = 0;
    mode = 1; en = 1; start = 1;
    step();
    start = 0;
    chk("os_busy0", busy, 1);
    step();
    start = 1;
    step();
    start = 0;
    step();
    chk("os_tick3", tick, 0);
    chk("os_busy3", busy, 1);
    step();
    chk("os_tick4", tick, 1);
    chk("os_cnt", tick_count, 10);
    step();
    chk("os_idle", busy, 0);
    seen = 0;
    repeat (10) begin
      step();
      seen += int'(tick) + int'(busy);
    end
    chk("os_single", seen, 0);

    // async reset mid-RUN
    mode = 0;
    repeat (4) step();
    chk("pre_rst_busy", busy, 1);
    #2;
    rst_n = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_tick", tick, 0);
    chk("arst_cnt", tick_count, 0);
    chk("arst_period", dut.period_act, 500_000);
    en = 0;
    #1;
    rst_n = 1;
    step();

    // invalid period 0 in IDLE
    period_ld = 1; period_in = 0;
    step();
    period_ld = 0;
    chk("err0_pulse", period_err, 1);
    step();
    chk("err0_clear", period_err, 0);
    chk("err0_keep", dut.period_act, 500_000);

    // tick_count wrap at 256 with P=2
    period_ld = 1; period_in = 2;
    step();
    period_ld = 0;
    en = 1;
    step();
    bad = 0;
    for (int i = 0; i < 255; i++) begin
      wait_tick(n);
      if (n != 2) bad++;
    end
    chk("wrap_255", tick_count, 255);
    wait_tick(n);
    if (n != 2) bad++;
    chk("wrap_0", tick_count, 0);
    chk("wrap_gaps", bad, 0);

`ifdef TICK_HALF_EN
    en = 0;
    step();
    period_ld = 1; period_in = 8;
    step();
    period_ld = 0;
    en = 1;
    step();
    bad = 0;
    seen = 0;
    for (int i = 1; i <= 16; i++) begin
      step();
      seen += int'(tick_half);
      if (tick_half != ((i % 8) == 3)) bad++;
    end
    chk("half_pos", bad, 0);
    chk("half_count", seen, 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      ncmp, nerr);
    $finish;
  end

endmodule
